// File: rtl/cacheline_adapter_if.sv
// Cache line port and backing-memory burst port of the cacheline adapter.
// slave is the adapter's view; master is the cache/memory side.
interface cacheline_adapter_if #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int ADDR_BITS = 32
);
  logic [ADDR_BITS-1:0] dfp_addr;
  logic                 dfp_read;
  logic                 dfp_write;
  logic [LINE_BITS-1:0] dfp_wdata;
  logic [LINE_BITS-1:0] dfp_rdata;
  logic                 dfp_resp;
  logic [ADDR_BITS-1:0] mem_addr;
  logic                 mem_read;
  logic                 mem_write;
  logic [BEAT_BITS-1:0] mem_wdata;
  logic                 mem_ready;
  logic [BEAT_BITS-1:0] mem_rdata;
  logic                 mem_rvalid;

  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp,
    output mem_addr, mem_read, mem_write, mem_wdata,
    input  mem_ready, mem_rdata, mem_rvalid
  );

  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp,
    input  mem_addr, mem_read, mem_write, mem_wdata,
    output mem_ready, mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/cacheline_adapter.sv
// Services whole-line cache reads/write-backs as BEATS-beat memory bursts.
// One transaction in flight; single-cycle dfp_resp on completion.
module cacheline_adapter #(
  parameter int LINE_BITS = 256,
  parameter int BEAT_BITS = 64,
  parameter int ADDR_BITS = 32
) (
  input logic clk,
  input logic rst,
  cacheline_adapter_if.slave io_bus
);
  localparam int BEATS = LINE_BITS / BEAT_BITS;
  localparam int CNT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam logic [CNT_BITS-1:0] LAST = CNT_BITS'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_BURST,
    S_RD_REQ,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_BITS-1:0]             r_cnt;
  logic [ADDR_BITS-1:0]            r_addr;
  logic [BEATS-1:0][BEAT_BITS-1:0] r_wline;
  logic [BEATS-1:0][BEAT_BITS-1:0] r_rbuf;
  logic [ADDR_BITS-1:0]            w_line_addr;
  logic                            w_last;

  assign w_line_addr = {io_bus.dfp_addr[ADDR_BITS-1:OFFSET_BITS],
                        {OFFSET_BITS{1'b0}}};
  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next            = r_state;
    io_bus.dfp_resp   = 1'b0;
    io_bus.dfp_rdata  = r_rbuf;
    io_bus.mem_addr   = r_addr;
    io_bus.mem_read   = 1'b0;
    io_bus.mem_write  = 1'b0;
    io_bus.mem_wdata  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (io_bus.dfp_write)     w_next = S_WR_BURST;
        else if (io_bus.dfp_read) w_next = S_RD_REQ;
      end
      S_WR_BURST: begin
        io_bus.mem_write = 1'b1;
        io_bus.mem_wdata = r_wline[r_cnt];
        if (io_bus.mem_ready && w_last) w_next = S_DONE;
      end
      S_RD_REQ: begin
        io_bus.mem_read = 1'b1;
        if (io_bus.mem_ready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        if (io_bus.mem_rvalid && w_last) w_next = S_DONE;
      end
      S_DONE: begin
        io_bus.dfp_resp = 1'b1;
        w_next          = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Read buffer only moves in RD_DATA so dfp_rdata survives write-backs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wline <= '0;
      r_rbuf  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (io_bus.dfp_write) begin
            r_addr  <= w_line_addr;
            r_wline <= io_bus.dfp_wdata;
            r_cnt   <= '0;
          end else if (io_bus.dfp_read) begin
            r_addr  <= w_line_addr;
          end
        end
        S_WR_BURST: begin
          if (io_bus.mem_ready) r_cnt <= r_cnt + CNT_BITS'(1);
        end
        S_RD_REQ: begin
          if (io_bus.mem_ready) r_cnt <= '0;
        end
        S_RD_DATA: begin
          if (io_bus.mem_rvalid) begin
            r_rbuf[r_cnt] <= io_bus.mem_rdata;
            r_cnt         <= r_cnt + CNT_BITS'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cacheline_adapter.sv
// Self-checking bench for cacheline_adapter: table vectors, hand corner
// sequences and randomized transactions against a transaction-level model.
module tb_cacheline_adapter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cacheline_adapter_if bus ();

  cacheline_adapter dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  typedef struct {
    logic         is_wr;
    logic         both;
    logic [31:0]  addr;
    logic [255:0] data;
    int           stall;
    int           gap;
    logic [31:0]  exp_addr;
  } vec_t;

  int total = 0;
  int bad = 0;
  logic [255:0] model_rdata = '0;
  int pat[$];

  task automatic check(input string name, input logic [255:0] got,
                       input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.dfp_read   = 1'b0;
    bus.dfp_write  = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  // Quiet period with spurious rvalid/ready: no commands, no resp, rdata held.
  task automatic idle_check(input string name, input int n);
    int err = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.mem_rvalid = 1'($urandom_range(1));
      bus.mem_rdata  = {$urandom, $urandom};
      bus.mem_ready  = 1'($urandom_range(1));
      @(negedge clk);
      if (bus.mem_read || bus.mem_write || bus.dfp_resp) err++;
      if (bus.dfp_rdata !== model_rdata) err++;
    end
    bus.mem_rvalid = 1'b0;
    check({name, "_idle"}, 256'(err), 256'd0);
  endtask

  task automatic run_write(input string name, input logic [31:0] addr,
                           input logic [255:0] line, input logic both,
                           input int stall);
    logic [63:0] got[$];
    logic [63:0] prev_wd = '0;
    logic        prev_stall = 1'b0;
    int resp_n = 0, cyc = 0, nstall = 0;
    int addr_err = 0, stab_err = 0, rd_err = 0, rdat_err = 0;
    logic [31:0] exp_a;
    exp_a = addr & ~32'h1F;
    @(posedge clk); #1;
    bus.dfp_addr  = addr;
    bus.dfp_wdata = line;
    bus.dfp_write = 1'b1;
    bus.dfp_read  = both;
    while (resp_n == 0 && cyc < 200) begin
      @(posedge clk); #1;
      if (pat.size() > 0) bus.mem_ready = 1'(pat.pop_front());
      else bus.mem_ready = ($urandom_range(99) >= stall);
      bus.mem_rvalid = 1'($urandom_range(1));
      bus.mem_rdata  = {$urandom, $urandom};
      @(negedge clk);
      cyc++;
      if (bus.mem_read) rd_err++;
      if (bus.dfp_rdata !== model_rdata) rdat_err++;
      if (bus.mem_write) begin
        if (bus.mem_addr !== exp_a) addr_err++;
        if (prev_stall && bus.mem_wdata !== prev_wd) stab_err++;
        if (bus.mem_ready) got.push_back(bus.mem_wdata);
        else nstall++;
        prev_stall = !bus.mem_ready;
        prev_wd    = bus.mem_wdata;
      end
      if (bus.dfp_resp) resp_n++;
    end
    @(posedge clk); #1;
    idle_inputs();
    check({name, "_resp"}, 256'(resp_n), 256'd1);
    check({name, "_nbeats"}, 256'(got.size()), 256'd4);
    for (int i = 0; i < got.size() && i < 4; i++)
      check($sformatf("%s_beat%0d", name, i), 256'(got[i]),
            256'(line[64*i +: 64]));
    check({name, "_lat"}, 256'(cyc), 256'(5 + nstall));
    check({name, "_addr_err"}, 256'(addr_err), 256'd0);
    check({name, "_stable_err"}, 256'(stab_err), 256'd0);
    check({name, "_no_read"}, 256'(rd_err), 256'd0);
    check({name, "_rdata_kept"}, 256'(rdat_err), 256'd0);
    idle_check(name, 3);
  endtask

  task automatic run_read(input string name, input logic [31:0] addr,
                          input logic [255:0] line, input int stall,
                          input int gap);
    int resp_n = 0, cyc = 0, idx = 0, acc_n = 0, last_beat = 0;
    int addr_err = 0, wr_err = 0;
    logic accepted = 1'b0;
    logic beat_drv;
    logic [255:0] rd_at_resp = '0;
    logic [31:0] exp_a;
    exp_a = addr & ~32'h1F;
    @(posedge clk); #1;
    bus.dfp_addr  = addr;
    bus.dfp_read  = 1'b1;
    bus.dfp_write = 1'b0;
    while (resp_n == 0 && cyc < 300) begin
      @(posedge clk); #1;
      bus.mem_ready = ($urandom_range(99) >= stall);
      beat_drv = accepted && idx < 4 && ($urandom_range(99) >= gap);
      if (beat_drv) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = line[64*idx +: 64];
      end else begin
        bus.mem_rvalid = !accepted && 1'($urandom_range(1));
        bus.mem_rdata  = {$urandom, $urandom};
      end
      @(negedge clk);
      cyc++;
      if (bus.mem_write) wr_err++;
      if (bus.mem_read) begin
        if (bus.mem_addr !== exp_a) addr_err++;
        if (accepted) wr_err++;
        if (bus.mem_ready) begin
          accepted = 1'b1;
          acc_n++;
        end
      end
      if (beat_drv) begin
        idx++;
        last_beat = cyc;
      end
      if (bus.dfp_resp) begin
        resp_n++;
        rd_at_resp = bus.dfp_rdata;
      end
    end
    @(posedge clk); #1;
    idle_inputs();
    model_rdata = line;
    check({name, "_resp"}, 256'(resp_n), 256'd1);
    check({name, "_rdata"}, rd_at_resp, line);
    check({name, "_cmd_acc"}, 256'(acc_n), 256'd1);
    check({name, "_lat"}, 256'(cyc), 256'(last_beat + 1));
    if (stall == 0 && gap == 0)
      check({name, "_lat6"}, 256'(cyc), 256'd6);
    check({name, "_addr_err"}, 256'(addr_err), 256'd0);
    check({name, "_proto_err"}, 256'(wr_err), 256'd0);
    idle_check(name, 3);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    check({name, "_align"}, 256'(v.addr & ~32'h1F), 256'(v.exp_addr));
    if (v.is_wr) run_write(name, v.addr, v.data, v.both, v.stall);
    else run_read(name, v.addr, v.data, v.stall, v.gap);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h0000_1234,
               {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}},
               0, 0, 32'h0000_1220};
    tbl[1] = '{1'b0, 1'b0, 32'h0000_0FE0,
               {64'h44, 64'h33, 64'h22, 64'h11}, 0, 40, 32'h0000_0FE0};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_8047,
               {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0},
               20, 0, 32'h0000_8040};
    tbl[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF,
               {64'hCAFE, 64'hBEEF, 64'hF00D, 64'hD00D}, 0, 0,
               32'hFFFF_FFE0};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_001F, {4{64'hFFFF_0000_1234_5678}},
               0, 0, 32'h0000_0000};

    bus.dfp_addr  = '0;
    bus.dfp_wdata = '0;
    idle_inputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {bus.dfp_resp, bus.mem_read, bus.mem_write, bus.mem_addr,
           bus.mem_wdata}, '0);
    check("reset_rdata", bus.dfp_rdata, '0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 5; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    pat = '{1, 0, 0, 1, 1, 0, 1};
    run_write("stallpat", 32'h0000_2000,
              {64'h4, 64'h3, 64'h2, 64'h1}, 1'b0, 0);

    // Reset after two read beats; partial data must be discarded.
    @(posedge clk); #1;
    bus.dfp_addr = 32'h0000_0400;
    bus.dfp_read = 1'b1;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_cmd", 256'(bus.mem_read), 256'd1);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 64'hBAD0;
    @(posedge clk); #1;
    bus.mem_rdata  = 64'hBAD1;
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_out",
          {bus.dfp_resp, bus.mem_read, bus.mem_write, bus.mem_addr,
           bus.mem_wdata}, '0);
    check("rst_async_rdata", bus.dfp_rdata, '0);
    model_rdata = '0;
    @(posedge clk); #1;
    idle_inputs();
    rst = 1'b0;
    run_read("rst_reread", 32'h0000_0400,
             {64'h7777, 64'h6666, 64'h5555, 64'h4444}, 0, 0);

    for (int i = 0; i < 20; i++) begin
      vec_t v;
      v.is_wr = 1'($urandom_range(1));
      v.both  = 1'($urandom_range(1));
      v.addr  = $urandom;
      v.data  = {$urandom, $urandom, $urandom, $urandom,
                 $urandom, $urandom, $urandom, $urandom};
      v.stall = $urandom_range(50);
      v.gap   = $urandom_range(50);
      v.exp_addr = {v.addr[31:5], 5'b0};
      run_vec($sformatf("rnd%0d", i), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
